// File: rtl/level_meter.sv
// level_meter: turns one peak word per analysis window into an LED bar graph
// with a fast attack and a timed decay. It also drives a peak-hold marker and
// a stretched full-scale clip flag. All outputs are registered.
module level_meter #(
    parameter int BUS_WIDTH    = 12,
    parameter int LOG2_LEDS    = 3,
    parameter int DECAY_CYCLES = 2205,
    parameter int HOLD_CYCLES  = 44100,
    parameter int CLIP_CYCLES  = 22050,
    parameter int TMR_W        = 16
) (
    input  logic                      dclk,
    input  logic                      rst,
    input  logic [BUS_WIDTH-1:0]      din,
    input  logic                      din_stb,
    output logic [2**LOG2_LEDS-1:0]   bar,
    output logic [2**LOG2_LEDS-1:0]   peak_led,
    output logic                      clip
);

    localparam int N  = 2**LOG2_LEDS;
    localparam int LW = LOG2_LEDS + 1;

    typedef logic [LW-1:0] lvl_t;
    typedef enum logic [1:0] {TRACK, HOLD, FALL} state_t;

    localparam logic [TMR_W-1:0] DECAY_LAST = TMR_W'(DECAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLIP_LAST  = TMR_W'(CLIP_CYCLES - 1);

    // Bit i is lit when i is below the level.
    function automatic logic [N-1:0] thermo(input lvl_t v);
        logic [N-1:0] t;
        for (int i = 0; i < N; i++) t[i] = (lvl_t'(i) < v);
        return t;
    endfunction

    // Level k lights bit k-1. Level 0 lights nothing.
    function automatic logic [N-1:0] onehot(input lvl_t v);
        logic [N-1:0] o;
        for (int i = 0; i < N; i++) o[i] = (lvl_t'(i + 1) == v);
        return o;
    endfunction

    lvl_t             lit, target, disp, disp_next, cur_lit, peak;
    logic             tick, attack, peak_load, full_scale;
    logic [TMR_W-1:0] dtmr, dtmr_next, htmr, ctmr;
    state_t           state;

    // Level mapping, decay tick and next bar level.
    always_comb begin
        lit = '0;
        if (din != '0) lit = {1'b0, din[BUS_WIDTH-1 -: LOG2_LEDS]} + lvl_t'(1);
        tick       = (dtmr == DECAY_LAST);
        target     = din_stb ? lit : cur_lit;
        attack     = din_stb && (lit >= disp);
        disp_next  = disp;
        dtmr_next  = tick ? '0 : dtmr + TMR_W'(1);
        if (attack) begin
            disp_next = lit;
            dtmr_next = '0;
        end else if (tick && (disp > target)) begin
            disp_next = disp - lvl_t'(1);
        end
        peak_load  = din_stb && (lit != '0) && (lit >= peak);
        full_scale = din_stb && (&din);
    end

    // Bar level, decay timer, last strobed level and bar output.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            disp    <= '0;
            dtmr    <= '0;
            cur_lit <= '0;
            bar     <= '0;
        end else begin
            disp <= disp_next;
            dtmr <= dtmr_next;
            if (din_stb) cur_lit <= lit;
            bar  <= thermo(disp_next);
        end
    end

    // Peak marker FSM. A new peak reloads the hold from any state. The marker
    // never sits below the bar, so leaving FALL snaps it onto the bar top.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            state    <= TRACK;
            peak     <= '0;
            htmr     <= '0;
            peak_led <= '0;
        end else if (peak_load) begin
            state    <= HOLD;
            peak     <= lit;
            htmr     <= HOLD_LAST;
            peak_led <= onehot(lit);
        end else begin
            case (state)
                TRACK: begin
                    peak     <= disp_next;
                    peak_led <= onehot(disp_next);
                end
                HOLD: begin
                    if (htmr == '0) state <= FALL;
                    else            htmr  <= htmr - TMR_W'(1);
                end
                FALL: begin
                    if (tick) begin
                        if (peak <= disp_next + lvl_t'(1)) begin
                            peak     <= disp_next;
                            peak_led <= onehot(disp_next);
                            state    <= TRACK;
                        end else begin
                            peak     <= peak - lvl_t'(1);
                            peak_led <= onehot(peak - lvl_t'(1));
                        end
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end

    // Clip flag. It is stretched for CLIP_CYCLES and restarted by each new full-scale word.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            clip <= 1'b0;
            ctmr <= '0;
        end else if (full_scale) begin
            clip <= 1'b1;
            ctmr <= CLIP_LAST;
        end else if (clip) begin
            if (ctmr == '0) clip <= 1'b0;
            else            ctmr <= ctmr - TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: scoreboard bench for level_meter with short timers.
`timescale 1ns/1ps
module tb_level_meter;

    localparam int DEC  = 4;
    localparam int HOLD = 8;
    localparam int CLP  = 6;

    logic        dclk = 1'b0;
    logic        rst  = 1'b0;
    logic [11:0] din  = '0;
    logic        din_stb = 1'b0;
    logic [7:0]  bar, peak_led;
    logic        clip;

    level_meter #(
        .BUS_WIDTH(12), .LOG2_LEDS(3), .DECAY_CYCLES(DEC),
        .HOLD_CYCLES(HOLD), .CLIP_CYCLES(CLP), .TMR_W(16)
    ) dut (
        .dclk(dclk), .rst(rst), .din(din), .din_stb(din_stb),
        .bar(bar), .peak_led(peak_led), .clip(clip)
    );

    always #5 dclk = ~dclk;

    typedef struct packed {
        logic [7:0] bar;
        logic [7:0] pk;
        logic       clip;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] obs_bar, obs_pk;
    logic       obs_clip;

    // Behavioural reference state (0 TRACK, 1 HOLD, 2 FALL)
    int m_disp, m_peak, m_cur, m_dtmr, m_htmr, m_ctmr, m_clip, m_state;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_disp = 0; m_peak = 0; m_cur = 0; m_dtmr = 0;
        m_htmr = 0; m_ctmr = 0; m_clip = 0; m_state = 0;
    endtask

    task automatic model_advance(input logic stb, input logic [11:0] d, output exp_t e);
        int lit, tgt, nd, ndt, np, nh, ns, nc, nct;
        bit tick;
        lit  = (d == 12'h000) ? 0 : int'(d[11:9]) + 1;
        tick = (m_dtmr == DEC - 1);
        tgt  = stb ? lit : m_cur;
        nd   = m_disp;
        ndt  = tick ? 0 : m_dtmr + 1;
        if (stb && lit >= m_disp) begin
            nd = lit; ndt = 0;
        end else if (tick && m_disp > tgt) begin
            nd = m_disp - 1;
        end
        np = m_peak; nh = m_htmr; ns = m_state;
        if (stb && lit != 0 && lit >= m_peak) begin
            np = lit; nh = HOLD - 1; ns = 1;
        end else if (m_state == 0) begin
            np = nd;
        end else if (m_state == 1) begin
            if (m_htmr == 0) ns = 2; else nh = m_htmr - 1;
        end else if (tick) begin
            if (m_peak - 1 <= nd) begin np = nd; ns = 0; end
            else np = m_peak - 1;
        end
        nc = m_clip; nct = m_ctmr;
        if (stb && d == 12'hFFF) begin
            nc = 1; nct = CLP - 1;
        end else if (m_clip != 0) begin
            if (m_ctmr == 0) nc = 0; else nct = m_ctmr - 1;
        end
        if (stb) m_cur = lit;
        m_disp = nd; m_dtmr = ndt; m_peak = np; m_htmr = nh; m_state = ns;
        m_clip = nc; m_ctmr = nct;
        e.bar  = 8'((1 << nd) - 1);
        e.pk   = (np == 0) ? 8'h00 : 8'(1 << (np - 1));
        e.clip = (nc != 0);
    endtask

    // One clock: drive at negedge, push the expectation, compare after the edge.
    task automatic step(input logic stb, input logic [11:0] d);
        exp_t e;
        @(negedge dclk);
        din = d;
        din_stb = stb;
        model_advance(stb, d, e);
        sb_q.push_back(e);
        @(posedge dclk);
        #1;
        din_stb = 1'b0;
        obs_bar = bar; obs_pk = peak_led; obs_clip = clip;
        e = sb_q.pop_front();
        check_val("bar", 32'(obs_bar), 32'(e.bar));
        check_val("peak_led", 32'(obs_pk), 32'(e.pk));
        check_val("clip", 32'(obs_clip), 32'(e.clip));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'($urandom));
    endtask

    // Assert reset away from the clock edge and check that the outputs clear before the next edge.
    task automatic reset_dut(input string tag);
        @(negedge dclk);
        rst = 1'b0;
        #1;
        check_val({tag, "_bar"}, 32'(bar), 32'h0);
        check_val({tag, "_pk"}, 32'(peak_led), 32'h0);
        check_val({tag, "_clip"}, 32'(clip), 32'h0);
        @(posedge dclk);
        @(negedge dclk);
        rst = 1'b1;
        model_reset();
    endtask

    logic [11:0] map_din [5] = '{12'h000, 12'h001, 12'h1FF, 12'h800, 12'hE00};
    logic [7:0]  map_bar [5] = '{8'h00, 8'h01, 8'h01, 8'h1F, 8'hFF};

    initial begin
        int cnt, lvl;
        bit found;
        logic [7:0] want_pk;

        model_reset();
        repeat (3) @(posedge dclk);
        reset_dut("rst0");

        // Idle after reset
        idle(50);
        check_val("idle_bar", 32'(obs_bar), 32'h00);
        check_val("idle_pk", 32'(obs_pk), 32'h00);

        // Level mapping
        for (int i = 0; i < 5; i++) begin
            step(1'b1, map_din[i]);
            check_val("map_bar", 32'(obs_bar), 32'(map_bar[i]));
        end

        // Attack, decay, and a mid-decay strobe below the bar
        reset_dut("rst1");
        step(1'b1, 12'hE00);
        check_val("attack_bar", 32'(obs_bar), 32'hFF);
        step(1'b1, 12'h000);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (obs_bar == 8'h3F) found = 1;
            else step(1'b0, 12'($urandom));
        end
        check_val("decay_reach6", 32'(found), 32'd1);
        step(1'b1, 12'h800);
        idle(30);
        check_val("decay_floor", 32'(obs_bar), 32'h1F);

        // Peak hold, fall and merge
        reset_dut("rst2");
        step(1'b1, 12'hE00);
        step(1'b1, 12'h000);
        check_val("hold_pk", 32'(obs_pk), 32'h80);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 12'($urandom));
            check_val("hold_pk", 32'(obs_pk), 32'h80);
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 12'($urandom));
            if (obs_bar == 8'h00 && obs_pk == 8'h00) found = 1;
        end
        check_val("peak_merge", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 12'($urandom));
            check_val("track_pk", 32'(obs_pk), 32'h00);
        end

        // Clip stretch, then re-clip on the 4th high cycle
        reset_dut("rst3");
        step(1'b1, 12'hFFF);
        cnt = obs_clip ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 12'($urandom));
            if (obs_clip) cnt++;
        end
        check_val("clip_len", 32'(cnt), 32'd6);
        step(1'b1, 12'hFFF);
        idle(2);
        step(1'b1, 12'hFFF);
        cnt = obs_clip ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 12'($urandom));
            if (obs_clip) cnt++;
        end
        check_val("reclip_len", 32'(cnt), 32'd6);

        // Strobe below the bar coinciding with a tick: one decrement
        reset_dut("rst4");
        step(1'b1, 12'hE00);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_dtmr == DEC - 1) found = 1;
            else step(1'b0, 12'($urandom));
        end
        check_val("tick_align", 32'(found), 32'd1);
        step(1'b1, 12'h000);
        check_val("stb_tick_bar", 32'(obs_bar), 32'h7F);

        // New peak during FALL re-enters HOLD
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_state == 2) found = 1;
            else step(1'b0, 12'($urandom));
        end
        check_val("reach_fall", 32'(found), 32'd1);
        lvl = m_peak;
        want_pk = 8'(1 << (lvl - 1));
        step(1'b1, 12'((lvl - 1) << 9));
        check_val("fall_reload_pk", 32'(obs_pk), 32'(want_pk));
        step(1'b1, 12'h000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 12'($urandom));
            check_val("rehold_pk", 32'(obs_pk), 32'(want_pk));
        end

        // Reset in the middle of a hold and a clip stretch
        step(1'b1, 12'hFFF);
        step(1'b0, 12'h000);
        reset_dut("rst_mid");
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout, 0 of 1 completions");
        $fatal(1, "timeout");
    end

endmodule
